// File: rtl/alu.sv
// Registered integer ALU: one op per cycle, result/tag/flags one clock later.
// Define ALU_FLAGS_EN to build the zero/carry/overflow logic; otherwise those ports are tied to 0.
module alu #(
    parameter int SIZE       = 32,
    parameter int ALUOP_BITS = 3,
    parameter int TAG_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [ALUOP_BITS-1:0] ALUOp,
    input  logic [SIZE-1:0]       in1,
    input  logic [SIZE-1:0]       in2,
    input  logic [TAG_BITS-1:0]   in_tag,
    output logic [SIZE-1:0]       out,
    output logic                  out_valid,
    output logic [TAG_BITS-1:0]   out_tag,
    output logic                  zero,
    output logic                  carry,
    output logic                  overflow
);

    localparam int SHW = $clog2(SIZE);

    localparam logic [ALUOP_BITS-1:0] OP_ADD = ALUOP_BITS'(0);
    localparam logic [ALUOP_BITS-1:0] OP_SUB = ALUOP_BITS'(1);
    localparam logic [ALUOP_BITS-1:0] OP_AND = ALUOP_BITS'(2);
    localparam logic [ALUOP_BITS-1:0] OP_XOR = ALUOP_BITS'(3);
    localparam logic [ALUOP_BITS-1:0] OP_SRA = ALUOP_BITS'(4);
    localparam logic [ALUOP_BITS-1:0] OP_OR  = ALUOP_BITS'(5);
    localparam logic [ALUOP_BITS-1:0] OP_SLL = ALUOP_BITS'(6);
    localparam logic [ALUOP_BITS-1:0] OP_SRL = ALUOP_BITS'(7);

    logic            is_sub;
    logic [SIZE-1:0] b_op;
    logic [SIZE:0]   sum_ext;
    logic [SHW-1:0]  shamt;
    logic [SIZE-1:0] result;

    // ADD and SUB share one adder; SUB is in1 + ~in2 + 1 so bit SIZE is the no-borrow flag.
    assign is_sub  = (ALUOp == OP_SUB);
    assign b_op    = is_sub ? ~in2 : in2;
    assign sum_ext = {1'b0, in1} + {1'b0, b_op} + {{SIZE{1'b0}}, is_sub};
    assign shamt   = in2[SHW-1:0];

    always_comb begin
        result = '0;
        case (ALUOp)
            OP_ADD:  result = sum_ext[SIZE-1:0];
            OP_SUB:  result = sum_ext[SIZE-1:0];
            OP_AND:  result = in1 & in2;
            OP_XOR:  result = in1 ^ in2;
            OP_SRA:  result = $signed(in1) >>> shamt;
            OP_OR:   result = in1 | in2;
            OP_SLL:  result = in1 << shamt;
            OP_SRL:  result = in1 >> shamt;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_tag   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out     <= result;
                out_tag <= in_tag;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    logic is_arith;
    logic carry_next;
    logic overflow_next;

    // Overflow when the effective addends share a sign and the sum's sign differs from in1.
    assign is_arith      = (ALUOp == OP_ADD) || (ALUOp == OP_SUB);
    assign carry_next    = is_arith & sum_ext[SIZE];
    assign overflow_next = is_arith & (in1[SIZE-1] == b_op[SIZE-1])
                                    & (sum_ext[SIZE-1] != in1[SIZE-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (in_valid) begin
            zero     <= (result == '0);
            carry    <= carry_next;
            overflow <= overflow_next;
        end
    end
`else
    logic unused_carry_bit;
    assign unused_carry_bit = sum_ext[SIZE];
    assign zero     = 1'b0;
    assign carry    = 1'b0;
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven bench for alu (SIZE=32); flag expectations follow the ALU_FLAGS_EN build.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  ALUOp;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  in_tag;
    logic [31:0] out;
    logic        out_valid;
    logic [3:0]  out_tag;
    logic        zero;
    logic        carry;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
    } vec_t;

    vec_t vq[$];

    alu #(.SIZE(32), .ALUOP_BITS(3), .TAG_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ALUOp(ALUOp),
        .in1(in1), .in2(in2), .in_tag(in_tag), .out(out), .out_valid(out_valid),
        .out_tag(out_tag), .zero(zero), .carry(carry), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic flagExp(input logic f);
`ifdef ALU_FLAGS_EN
        return f;
`else
        return 1'b0;
`endif
    endfunction

    function automatic vec_t mkVec(input string name, input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] tag, input logic [31:0] res,
                                   input logic z, input logic c, input logic o);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.tag = tag;
        v.res = res; v.z = z; v.c = c; v.o = o;
        return v;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic exp_valid, input logic [31:0] exp_out,
                               input logic [3:0] exp_tag, input logic z, input logic c, input logic o);
        compare({name, ".out_valid"}, {31'b0, out_valid}, {31'b0, exp_valid});
        compare({name, ".out"}, out, exp_out);
        compare({name, ".out_tag"}, {28'b0, out_tag}, {28'b0, exp_tag});
        compare({name, ".zero"}, {31'b0, zero}, {31'b0, flagExp(z)});
        compare({name, ".carry"}, {31'b0, carry}, {31'b0, flagExp(c)});
        compare({name, ".overflow"}, {31'b0, overflow}, {31'b0, flagExp(o)});
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] tag);
        @(negedge clk);
        in_valid = valid;
        ALUOp    = op;
        in1      = a;
        in2      = b;
        in_tag   = tag;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; ALUOp = 3'd0; in1 = '0; in2 = '0; in_tag = '0;

        vq.push_back(mkVec("add_5_7",      3'd0, 32'h5,        32'h7,        4'd3, 32'hC,        0, 0, 0));
        vq.push_back(mkVec("add_ovf",      3'd0, 32'h7FFFFFFF, 32'h1,        4'd1, 32'h80000000, 0, 0, 1));
        vq.push_back(mkVec("add_wrap",     3'd0, 32'hFFFFFFFF, 32'h1,        4'd2, 32'h0,        1, 1, 0));
        vq.push_back(mkVec("sub_borrow",   3'd1, 32'h3,        32'h5,        4'd4, 32'hFFFFFFFE, 0, 0, 0));
        vq.push_back(mkVec("sub_5_3",      3'd1, 32'h5,        32'h3,        4'd5, 32'h2,        0, 1, 0));
        vq.push_back(mkVec("sub_ovf",      3'd1, 32'h80000000, 32'h1,        4'd6, 32'h7FFFFFFF, 0, 1, 1));
        vq.push_back(mkVec("sub_zero",     3'd1, 32'h7,        32'h7,        4'd7, 32'h0,        1, 1, 0));
        vq.push_back(mkVec("and",          3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 4'd8, 32'hF000F000, 0, 0, 0));
        vq.push_back(mkVec("xor",          3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 4'd9, 32'h0FF00FF0, 0, 0, 0));
        vq.push_back(mkVec("or",           3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 4'hA, 32'hFFF0FFF0, 0, 0, 0));
        vq.push_back(mkVec("and_zero",     3'd2, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'hB, 32'h0,        1, 0, 0));
        vq.push_back(mkVec("sra_neg",      3'd4, 32'h80000000, 32'h4,        4'hC, 32'hF8000000, 0, 0, 0));
        vq.push_back(mkVec("srl",          3'd7, 32'h80000000, 32'h4,        4'hD, 32'h08000000, 0, 0, 0));
        vq.push_back(mkVec("sll_31",       3'd6, 32'h1,        32'h1F,       4'hE, 32'h80000000, 0, 0, 0));
        vq.push_back(mkVec("sra_masked",   3'd4, 32'h80000000, 32'h24,       4'hF, 32'hF8000000, 0, 0, 0));
        vq.push_back(mkVec("sra_pos",      3'd4, 32'h40000000, 32'h4,        4'h1, 32'h04000000, 0, 0, 0));
        vq.push_back(mkVec("sll_masked",   3'd6, 32'h1,        32'h20,       4'h2, 32'h1,        0, 0, 0));
        vq.push_back(mkVec("srl_to_zero",  3'd7, 32'h1,        32'h1,        4'h3, 32'h0,        1, 0, 0));

        // Asynchronous reset: outputs clear mid-cycle without a clock edge.
        #2;
        checkOutput("reset_initial", 0, 32'h0, 4'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 3'd0, 32'hFFFFFFFF, 32'h1, 4'h9);
        @(posedge clk); #1;
        checkOutput("pre_reset_op", 1, 32'h0, 4'h9, 1, 1, 0);
        applyStimulus(0, 3'd0, 32'h0, 32'h0, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_async", 0, 32'h0, 4'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(1, vq[i].op, vq[i].a, vq[i].b, vq[i].tag);
            @(posedge clk); #1;
            checkOutput(vq[i].name, 1, vq[i].res, vq[i].tag, vq[i].z, vq[i].c, vq[i].o);
        end

        // Back-to-back stream of four ops with tags 0..3.
        applyStimulus(1, 3'd0, 32'd10, 32'd20, 4'd0);
        @(posedge clk); #1;
        checkOutput("stream0", 1, 32'd30, 4'd0, 0, 0, 0);
        applyStimulus(1, 3'd1, 32'd100, 32'd1, 4'd1);
        @(posedge clk); #1;
        checkOutput("stream1", 1, 32'd99, 4'd1, 0, 1, 0);
        applyStimulus(1, 3'd3, 32'hFFFF0000, 32'h0F0F0F0F, 4'd2);
        @(posedge clk); #1;
        checkOutput("stream2", 1, 32'hF0F00F0F, 4'd2, 0, 0, 0);
        applyStimulus(1, 3'd6, 32'h3, 32'h4, 4'd3);
        @(posedge clk); #1;
        checkOutput("stream3", 1, 32'h30, 4'd3, 0, 0, 0);

        // Idle inputs must not disturb the held result.
        applyStimulus(0, 3'd0, 32'h0, 32'h0, 4'hF);
        @(posedge clk); #1;
        checkOutput("hold1", 0, 32'h30, 4'd3, 0, 0, 0);
        applyStimulus(0, 3'd1, 32'h7, 32'h7, 4'hA);
        @(posedge clk); #1;
        checkOutput("hold2", 0, 32'h30, 4'd3, 0, 0, 0);

        // Reset while an operation is in flight discards it.
        applyStimulus(1, 3'd0, 32'h7FFFFFFF, 32'h1, 4'h5);
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset_inflight", 0, 32'h0, 4'h0, 0, 0, 0);
        applyStimulus(0, 3'd0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b1;

        // First op after reset release, per the reset test sequence.
        applyStimulus(1, 3'd0, 32'h5, 32'h7, 4'd3);
        @(posedge clk); #1;
        checkOutput("post_reset_add", 1, 32'hC, 4'd3, 0, 0, 0);
        applyStimulus(0, 3'd0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        checkOutput("post_reset_idle", 0, 32'hC, 4'd3, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
